mem_stall_model: RTL

- Parametrised, multi-port memory responder for formal and simulation environments around core_top.
- Drives the req/gnt side of NPORTS memory channels (imem, dmem, and later extra masters).
- Each grant is delayed by a nondeterministic but bounded stall, so liveness can be proven.
- Supplies the read data and error response at grant, checks the requester's protocol, and counts completed transactions per port.

---
 rtl/mem_model_pkg.sv | 23 ++
 rtl/mem_stall_port.sv | 134 +++++++++++++
 rtl/mem_stall_model.sv | 58 +++++
 3 files changed

// File: rtl/mem_model_pkg.sv
// Shared types for the stall-injecting memory responder: port state, capture
// widths and the captured-request record.
package mem_model_pkg;

  localparam int CAP_ADDR_W  = 64;
  localparam int CAP_DATA_W  = 64;
  localparam int STRB_W      = CAP_DATA_W / 8;
  localparam int STALL_CNT_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } port_state_e;

  // Requests are zero-extended into this record so one compare covers all fields.
  typedef struct packed {
    logic [CAP_ADDR_W-1:0] addr;
    logic                  wen;
    logic [STRB_W-1:0]     strb;
    logic [CAP_DATA_W-1:0] wdata;
  } mem_req_cap_t;

endpackage

// File: rtl/mem_stall_port.sv
// One memory channel: bounded-stall grant FSM, request capture and protocol
// checker, and a wrapping completed-transaction counter.
module mem_stall_port
  import mem_model_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MAX_STALL = 4,
  parameter int STALL_W   = 3,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                wen,
  input  logic [DATA_W/8-1:0] strb,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [STALL_W-1:0]  nd_stall,
  input  logic [DATA_W-1:0]   nd_rdata,
  input  logic                nd_err,
  output logic                gnt,
  output logic                err,
  output logic [DATA_W-1:0]   rdata,
  output logic                proto_viol,
  output logic [CNT_W-1:0]    txn_count
);

  port_state_e        state_q, state_d;
  logic [STALL_W-1:0] cnt_q, cnt_d;
  mem_req_cap_t       cap_q, cap_d;
  logic               viol_q, viol_d;
  logic [CNT_W-1:0]   txn_q, txn_d;

  logic [STALL_W-1:0] stall_s;
  mem_req_cap_t       cur_s;
  logic               gnt_s;

  always_comb begin
    cur_s       = '0;
    cur_s.addr  = CAP_ADDR_W'(addr);
    cur_s.wen   = wen;
    cur_s.strb  = STRB_W'(strb);
    cur_s.wdata = CAP_DATA_W'(wdata);
    if (nd_stall > STALL_W'(MAX_STALL)) begin
      stall_s = STALL_W'(MAX_STALL);
    end else begin
      stall_s = nd_stall;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    viol_d  = viol_q;
    txn_d   = txn_q;
    gnt_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (stall_s == '0) begin
            gnt_s = 1'b1;
            txn_d = txn_q + CNT_W'(1);
          end else begin
            cnt_d   = stall_s - STALL_W'(1);
            cap_d   = cur_s;
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // A dropped or altered request aborts without grant; any new request waits for IDLE.
        if (!req || (cur_s != cap_q)) begin
          viol_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          gnt_s   = 1'b1;
          txn_d   = txn_q + CNT_W'(1);
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - STALL_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (rst) begin
      gnt_s = 1'b0;
    end else begin
      gnt_s = gnt_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      viol_q  <= 1'b0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      viol_q  <= viol_d;
      txn_q   <= txn_d;
    end
  end

  always_comb begin
    if (gnt_s && !wen) begin
      rdata = nd_rdata;
    end else begin
      rdata = '0;
    end
  end

`ifdef MEM_STALL_MODEL_ERR_INJ_EN
  assign err = nd_err & gnt_s;
`else
  logic unused_nd_err_s;
  assign unused_nd_err_s = nd_err;
  assign err = 1'b0;
`endif

  assign gnt        = gnt_s;
  assign proto_viol = viol_q;
  assign txn_count  = txn_q;

endmodule

// File: rtl/mem_stall_model.sv
// Multi-port memory responder with bounded nondeterministic grant stalls.
// Define MEM_STALL_MODEL_ERR_INJ_EN to drive mem_err from nd_err at grant.
module mem_stall_model
  import mem_model_pkg::*;
#(
  parameter int NPORTS     = 2,
  parameter int MEM_ADDR_W = 64,
  parameter int MEM_DATA_W = 64,
  parameter int MAX_STALL  = 4,
  parameter int STALL_W    = 3,
  parameter int CNT_W      = 16
) (
  input  logic                           g_clk,
  input  logic                           g_reset,
  input  logic [NPORTS-1:0]              mem_req,
  input  logic [NPORTS*MEM_ADDR_W-1:0]   mem_addr,
  input  logic [NPORTS-1:0]              mem_wen,
  input  logic [NPORTS*MEM_DATA_W/8-1:0] mem_strb,
  input  logic [NPORTS*MEM_DATA_W-1:0]   mem_wdata,
  input  logic [NPORTS*STALL_W-1:0]      nd_stall,
  input  logic [NPORTS*MEM_DATA_W-1:0]   nd_rdata,
  input  logic [NPORTS-1:0]              nd_err,
  output logic [NPORTS-1:0]              mem_gnt,
  output logic [NPORTS-1:0]              mem_err,
  output logic [NPORTS*MEM_DATA_W-1:0]   mem_rdata,
  output logic [NPORTS-1:0]              proto_viol,
  output logic [NPORTS*CNT_W-1:0]        txn_count
);

  localparam int MEM_STRB_W = MEM_DATA_W / 8;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    mem_stall_port #(
      .ADDR_W    (MEM_ADDR_W),
      .DATA_W    (MEM_DATA_W),
      .MAX_STALL (MAX_STALL),
      .STALL_W   (STALL_W),
      .CNT_W     (CNT_W)
    ) u_port (
      .clk        (g_clk),
      .rst        (g_reset),
      .req        (mem_req[p]),
      .addr       (mem_addr[p*MEM_ADDR_W +: MEM_ADDR_W]),
      .wen        (mem_wen[p]),
      .strb       (mem_strb[p*MEM_STRB_W +: MEM_STRB_W]),
      .wdata      (mem_wdata[p*MEM_DATA_W +: MEM_DATA_W]),
      .nd_stall   (nd_stall[p*STALL_W +: STALL_W]),
      .nd_rdata   (nd_rdata[p*MEM_DATA_W +: MEM_DATA_W]),
      .nd_err     (nd_err[p]),
      .gnt        (mem_gnt[p]),
      .err        (mem_err[p]),
      .rdata      (mem_rdata[p*MEM_DATA_W +: MEM_DATA_W]),
      .proto_viol (proto_viol[p]),
      .txn_count  (txn_count[p*CNT_W +: CNT_W])
    );
  end

endmodule
